// File: rtl/arb_defs.sv
// Shared definitions for the memory port arbiter: FSM encodings,
// requester identifiers and the data pattern returned on an aborted read.
package arb_defs;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_ACK  = 2'd3
    } arb_state_t;

    localparam logic        OWNER_I  = 1'b0;
    localparam logic        OWNER_D  = 1'b1;
    localparam logic [31:0] BAD_DATA = 32'hDEADBEEF;
    localparam logic [3:0]  BE_ALL   = 4'hF;

    // Reads always present all byte lanes to the memory.
    function automatic logic [3:0] mem_be_for(input logic we, input logic [3:0] be);
        return we ? be : BE_ALL;
    endfunction

endpackage

// File: rtl/arb_timeout_cnt.sv
// Loadable down-counter with a terminal-count flag; bounds the read wait
// of the arbiter when ARB_TIMEOUT_EN is defined.
module arb_timeout_cnt #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_en,
    output logic             o_tc
);

    logic [CNT_W-1:0] r_cnt;

    // Load on entry to the wait, then count down to zero and stop.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - 1'b1;
        end
    end

    assign o_tc = i_en && (r_cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between the instruction-fetch port and
// the data load/store port. One transaction at a time, all outputs registered.
// Optional macro ARB_TIMEOUT_EN: aborts a read wait after TIMEOUT cycles,
// returns BAD_DATA to the owner and sets the sticky err flag.
module mem_port_arbiter
    import arb_defs::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [3:0]        mem_be,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err
);

    localparam int                  STREAK_W   = $clog2(MAX_D_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

    arb_state_t          r_state,     w_state_nxt;
    logic                r_owner,     w_owner_nxt;
    logic [STREAK_W-1:0] r_streak,    w_streak_nxt;
    logic                r_i_ack,     w_i_ack_nxt;
    logic                r_d_ack,     w_d_ack_nxt;
    logic [DATA_W-1:0]   r_i_rdata,   w_i_rdata_nxt;
    logic [DATA_W-1:0]   r_d_rdata,   w_d_rdata_nxt;
    logic                r_mem_req,   w_mem_req_nxt;
    logic                r_mem_we,    w_mem_we_nxt;
    logic [3:0]          r_mem_be,    w_mem_be_nxt;
    logic [ADDR_W-1:0]   r_mem_addr,  w_mem_addr_nxt;
    logic [DATA_W-1:0]   r_mem_wdata, w_mem_wdata_nxt;

    logic                w_finish;
    logic                w_capture;
    logic [DATA_W-1:0]   w_cap_data;
    logic                w_tmo_load;
    logic                w_tmo_tc;

`ifdef ARB_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    logic r_err, w_err_nxt;

    arb_timeout_cnt #(
        .CNT_W (TMO_W)
    ) u_timeout_cnt (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_tmo_load),
        .i_load_val (TMO_W'(TIMEOUT - 1)),
        .i_en       (r_state == ST_WAIT),
        .o_tc       (w_tmo_tc)
    );

    assign err = r_err;
`else
    logic w_unused_timeout;

    assign w_unused_timeout = (TIMEOUT > 0) | w_tmo_load;
    assign w_tmo_tc         = 1'b0;
    assign err              = 1'b0;
`endif

    // State and every output register; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_owner     <= OWNER_I;
            r_streak    <= '0;
            r_i_ack     <= 1'b0;
            r_d_ack     <= 1'b0;
            r_i_rdata   <= '0;
            r_d_rdata   <= '0;
            r_mem_req   <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_be    <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
`ifdef ARB_TIMEOUT_EN
            r_err       <= 1'b0;
`endif
        end else begin
            r_state     <= w_state_nxt;
            r_owner     <= w_owner_nxt;
            r_streak    <= w_streak_nxt;
            r_i_ack     <= w_i_ack_nxt;
            r_d_ack     <= w_d_ack_nxt;
            r_i_rdata   <= w_i_rdata_nxt;
            r_d_rdata   <= w_d_rdata_nxt;
            r_mem_req   <= w_mem_req_nxt;
            r_mem_we    <= w_mem_we_nxt;
            r_mem_be    <= w_mem_be_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
`ifdef ARB_TIMEOUT_EN
            r_err       <= w_err_nxt;
`endif
        end
    end

    // Next-state and next-output logic; acks default low so they pulse once.
    always_comb begin
        w_state_nxt     = r_state;
        w_owner_nxt     = r_owner;
        w_streak_nxt    = r_streak;
        w_i_ack_nxt     = 1'b0;
        w_d_ack_nxt     = 1'b0;
        w_i_rdata_nxt   = r_i_rdata;
        w_d_rdata_nxt   = r_d_rdata;
        w_mem_req_nxt   = r_mem_req;
        w_mem_we_nxt    = r_mem_we;
        w_mem_be_nxt    = r_mem_be;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        w_finish        = 1'b0;
        w_capture       = 1'b0;
        w_cap_data      = mem_rdata;
        w_tmo_load      = 1'b0;
`ifdef ARB_TIMEOUT_EN
        w_err_nxt       = r_err;
`endif

        case (r_state)
            ST_IDLE: begin
                if (d_req && (!i_req || (r_streak < STREAK_MAX))) begin
                    w_owner_nxt     = OWNER_D;
                    w_mem_req_nxt   = 1'b1;
                    w_mem_we_nxt    = d_we;
                    w_mem_be_nxt    = mem_be_for(d_we, d_be);
                    w_mem_addr_nxt  = d_addr;
                    w_mem_wdata_nxt = d_wdata;
                    w_state_nxt     = ST_REQ;
                    if (i_req && (r_streak != STREAK_MAX)) begin
                        w_streak_nxt = r_streak + 1'b1;
                    end
                end else if (i_req) begin
                    w_owner_nxt     = OWNER_I;
                    w_mem_req_nxt   = 1'b1;
                    w_mem_we_nxt    = 1'b0;
                    w_mem_be_nxt    = BE_ALL;
                    w_mem_addr_nxt  = i_addr;
                    w_mem_wdata_nxt = '0;
                    w_streak_nxt    = '0;
                    w_state_nxt     = ST_REQ;
                end
            end
            ST_REQ: begin
                if (mem_ready) begin
                    w_mem_req_nxt = 1'b0;
                    if (r_mem_we) begin
                        w_finish = 1'b1;
                    end else begin
                        w_tmo_load  = 1'b1;
                        w_state_nxt = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (mem_rvalid) begin
                    w_finish  = 1'b1;
                    w_capture = 1'b1;
                end else if (w_tmo_tc) begin
                    w_finish   = 1'b1;
                    w_capture  = 1'b1;
                    w_cap_data = DATA_W'(BAD_DATA);
`ifdef ARB_TIMEOUT_EN
                    w_err_nxt  = 1'b1;
`endif
                end
            end
            ST_ACK: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        if (w_finish) begin
            w_state_nxt = ST_ACK;
            if (r_owner == OWNER_D) begin
                w_d_ack_nxt = 1'b1;
            end else begin
                w_i_ack_nxt = 1'b1;
            end
        end

        if (w_capture) begin
            if (r_owner == OWNER_D) begin
                w_d_rdata_nxt = w_cap_data;
            end else begin
                w_i_rdata_nxt = w_cap_data;
            end
        end
    end

    assign i_ack     = r_i_ack;
    assign d_ack     = r_d_ack;
    assign i_rdata   = r_i_rdata;
    assign d_rdata   = r_d_rdata;
    assign mem_req   = r_mem_req;
    assign mem_we    = r_mem_we;
    assign mem_be    = r_mem_be;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios followed by
// randomized traffic checked against a transaction-level model of the
// arbitration and handshake rules.
module tb_mem_port_arbiter;

    localparam int ADDR_W       = 32;
    localparam int DATA_W       = 32;
    localparam int MAX_D_STREAK = 4;
    localparam int TIMEOUT      = 8;

    logic              clk;
    logic              reset;
    logic              i_req;
    logic [ADDR_W-1:0] i_addr;
    logic              i_ack;
    logic [DATA_W-1:0] i_rdata;
    logic              d_req;
    logic              d_we;
    logic [3:0]        d_be;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    logic              d_ack;
    logic [DATA_W-1:0] d_rdata;
    logic              mem_req;
    logic              mem_we;
    logic [3:0]        mem_be;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ready;
    logic              mem_rvalid;
    logic [DATA_W-1:0] mem_rdata;
    logic              err;

    int          checks = 0;
    int          passes = 0;
    int          fails  = 0;
    int          streak = 0;
    logic [31:0] exp_i_rdata = '0;
    logic [31:0] exp_d_rdata = '0;

    mem_port_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .MAX_D_STREAK (MAX_D_STREAK),
        .TIMEOUT      (TIMEOUT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .i_req      (i_req),
        .i_addr     (i_addr),
        .i_ack      (i_ack),
        .i_rdata    (i_rdata),
        .d_req      (d_req),
        .d_we       (d_we),
        .d_be       (d_be),
        .d_addr     (d_addr),
        .d_wdata    (d_wdata),
        .d_ack      (d_ack),
        .d_rdata    (d_rdata),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_be     (mem_be),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .err        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: got %08h want %08h", tag, obs, exp);
        end
    endtask

    task automatic apply_reset();
        reset      = 1'b1;
        i_req      = 1'b0;
        d_req      = 1'b0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        cyc();
        cyc();
        reset       = 1'b0;
        streak      = 0;
        exp_i_rdata = '0;
        exp_d_rdata = '0;
        cyc();
    endtask

    // Raise new requests on idle ports; at least one port ends up requesting.
    task automatic new_reqs();
        if (!i_req && ($urandom_range(0, 2) != 0)) begin
            i_req  = 1'b1;
            i_addr = $urandom & 32'hFFFF_FFFC;
        end
        if (!d_req && (!i_req || ($urandom_range(0, 2) != 0))) begin
            d_req   = 1'b1;
            d_we    = 1'($urandom_range(0, 1));
            d_be    = 4'($urandom_range(1, 15));
            d_addr  = $urandom & 32'hFFFF_FFFC;
            d_wdata = $urandom;
        end
    endtask

    // One randomized transaction, entered and left at an idle-cycle negedge.
    task automatic rand_txn();
        logic        win_d;
        logic        is_wr;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        logic [31:0] rd;
        logic [3:0]  e_be;
        int          dly;
        new_reqs();
        win_d = d_req && (!i_req || (streak < MAX_D_STREAK));
        if (win_d) begin
            if (i_req && (streak < MAX_D_STREAK)) streak++;
            e_addr  = d_addr;
            is_wr   = d_we;
            e_be    = d_we ? d_be : 4'hF;
            e_wdata = d_wdata;
        end else begin
            streak  = 0;
            e_addr  = i_addr;
            is_wr   = 1'b0;
            e_be    = 4'hF;
            e_wdata = '0;
        end
        cyc();
        chk("grant_req", 32'(mem_req), 1);
        chk("grant_addr", mem_addr, e_addr);
        chk("grant_we", 32'(mem_we), 32'(is_wr));
        chk("grant_be", 32'(mem_be), 32'(e_be));
        if (is_wr) chk("grant_wdata", mem_wdata, e_wdata);
        if ($urandom_range(0, 7) == 0) begin
            if (win_d) d_req = 1'b0;
            else       i_req = 1'b0;
        end
        dly = $urandom_range(0, 3);
        repeat (dly) begin
            mem_rvalid = 1'($urandom_range(0, 1));
            mem_rdata  = $urandom;
            cyc();
            chk("hold_req", 32'(mem_req), 1);
            chk("hold_addr", mem_addr, e_addr);
            chk("hold_be", 32'(mem_be), 32'(e_be));
            chk("hold_ack", 32'({i_ack, d_ack}), 0);
        end
        mem_ready  = 1'b1;
        mem_rvalid = 1'($urandom_range(0, 1));
        mem_rdata  = $urandom;
        cyc();
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        chk("drop_req", 32'(mem_req), 0);
        if (!is_wr) begin
            dly = $urandom_range(0, 3);
            repeat (dly) begin
                cyc();
                chk("wait_ack", 32'({i_ack, d_ack}), 0);
            end
            rd         = $urandom;
            mem_rvalid = 1'b1;
            mem_rdata  = rd;
            cyc();
            mem_rvalid = 1'($urandom_range(0, 1));
            mem_rdata  = $urandom;
            if (win_d) exp_d_rdata = rd;
            else       exp_i_rdata = rd;
        end
        chk("ack_i", 32'(i_ack), 32'(!win_d));
        chk("ack_d", 32'(d_ack), 32'(win_d));
        chk("rdata_i", i_rdata, exp_i_rdata);
        chk("rdata_d", d_rdata, exp_d_rdata);
        chk("err_clear", 32'(err), 0);
        if (win_d) d_req = 1'b0;
        else       i_req = 1'b0;
        cyc();
        mem_rvalid = 1'b0;
        chk("ack_pulse", 32'({i_ack, d_ack}), 0);
    endtask

    initial begin
        string       exp_order;
        logic [7:0]  got;
        reset      = 1'b1;
        i_req      = 1'b0;
        i_addr     = '0;
        d_req      = 1'b0;
        d_we       = 1'b0;
        d_be       = '0;
        d_addr     = '0;
        d_wdata    = '0;
        mem_ready  = 1'b0;
        mem_rvalid = 1'b0;
        mem_rdata  = '0;

        // Reset values while reset is held.
        cyc();
        cyc();
        chk("rst_acks", 32'({i_ack, d_ack}), 0);
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_mem_be", 32'(mem_be), 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_rdata", i_rdata | d_rdata, 0);
        chk("rst_err", 32'(err), 0);
        reset = 1'b0;
        cyc();

        // Fetch only, zero-wait memory: ack three cycles after the request.
        i_req  = 1'b1;
        i_addr = 32'h100;
        cyc();
        chk("f_mem_req", 32'(mem_req), 1);
        chk("f_mem_addr", mem_addr, 32'h100);
        chk("f_mem_be", 32'(mem_be), 32'hF);
        chk("f_mem_we", 32'(mem_we), 0);
        mem_ready = 1'b1;
        cyc();
        mem_ready  = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0050_0093;
        chk("f_no_early_ack", 32'(i_ack), 0);
        cyc();
        mem_rvalid = 1'b0;
        chk("f_ack", 32'(i_ack), 1);
        chk("f_d_ack", 32'(d_ack), 0);
        chk("f_rdata", i_rdata, 32'h0050_0093);
        i_req = 1'b0;
        exp_i_rdata = 32'h0050_0093;
        streak = 0;
        cyc();
        chk("f_ack_pulse", 32'(i_ack), 0);
        chk("f_rdata_hold", i_rdata, 32'h0050_0093);

        // Store with mem_ready held off three cycles.
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_be    = 4'b0011;
        d_addr  = 32'h2004;
        d_wdata = 32'hCAFE_1234;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("s_req", 32'(mem_req), 1);
            chk("s_addr", mem_addr, 32'h2004);
            chk("s_be", 32'(mem_be), 32'h3);
            chk("s_we", 32'(mem_we), 1);
            chk("s_wdata", mem_wdata, 32'hCAFE_1234);
            chk("s_no_ack", 32'(d_ack), 0);
        end
        mem_ready = 1'b1;
        cyc();
        mem_ready = 1'b0;
        chk("s_ack", 32'(d_ack), 1);
        chk("s_mem_req_drop", 32'(mem_req), 0);
        chk("s_i_ack", 32'(i_ack), 0);
        d_req = 1'b0;
        cyc();
        chk("s_ack_pulse", 32'(d_ack), 0);

        // Both ports requesting continuously, zero-wait memory.
        apply_reset();
        exp_order = "DDDDIDDDDI";
        i_req   = 1'b1;
        i_addr  = 32'h400;
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_be    = 4'hF;
        d_addr  = 32'h800;
        d_wdata = 32'h1111_2222;
        for (int g = 0; g < 10; g++) begin
            cyc();
            got = (mem_addr == 32'h800) ? 8'(68) : ((mem_addr == 32'h400) ? 8'(73) : 8'(63));
            chk($sformatf("cont_grant%0d", g), 32'(got), 32'(exp_order[g]));
            mem_ready = 1'b1;
            cyc();
            mem_ready = 1'b0;
            if (got == 8'(73)) begin
                mem_rvalid = 1'b1;
                mem_rdata  = 32'(g);
                cyc();
                mem_rvalid = 1'b0;
                chk("cont_i_ack", 32'(i_ack), 1);
            end else begin
                chk("cont_d_ack", 32'(d_ack), 1);
            end
            cyc();
        end

        // Reset while waiting for read data, then a stale response.
        apply_reset();
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h3000;
        cyc();
        mem_ready = 1'b1;
        cyc();
        mem_ready = 1'b0;
        cyc();
        reset = 1'b1;
        d_req = 1'b0;
        cyc();
        reset      = 1'b0;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1234_5678;
        cyc();
        mem_rvalid = 1'b0;
        chk("rw_d_ack", 32'(d_ack), 0);
        chk("rw_d_rdata", d_rdata, 0);
        chk("rw_mem_req", 32'(mem_req), 0);
        cyc();
        chk("rw_d_ack2", 32'(d_ack), 0);
        chk("rw_d_rdata2", d_rdata, 0);
        chk("rw_idle", 32'(mem_req), 0);
        streak = 0;

        // Randomized traffic against the transaction model.
        for (int t = 0; t < 300; t++) rand_txn();

`ifdef ARB_TIMEOUT_EN
        // Load that never returns data: aborts after TIMEOUT wait cycles.
        apply_reset();
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 32'h4000;
        cyc();
        mem_ready = 1'b1;
        cyc();
        mem_ready = 1'b0;
        repeat (TIMEOUT - 1) begin
            cyc();
            chk("to_no_ack", 32'(d_ack), 0);
        end
        cyc();
        chk("to_ack", 32'(d_ack), 1);
        chk("to_rdata", d_rdata, 32'hDEAD_BEEF);
        chk("to_err", 32'(err), 1);
        d_req = 1'b0;
        repeat (3) cyc();
        chk("to_err_sticky", 32'(err), 1);
        apply_reset();
        chk("to_err_reset", 32'(err), 0);
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one single-port unified memory between the CPU's instruction-fetch port and its data load/store port. Grants one transaction at a time, drives the memory request/response handshake, and returns a one-cycle ack plus read data to the winning requester. The pipeline stalls on missing acks. Sits between the CPU core and the memory model at top level.

Parameters:
ADDR_W, 32, address width of all ports
DATA_W, 32, data width of all ports
MAX_D_STREAK, 4, consecutive data grants allowed while a fetch is pending before the fetch is forced
TIMEOUT, 64, cycles in a read wait before abort (used only with ARB_TIMEOUT_EN)

Ports:
clk  in  1  clock, all logic on rising edge
reset  in  1  synchronous, active-high
i_req  in  1  fetch request, held until i_ack
i_addr  in  ADDR_W  fetch address (PC)
i_ack  out  1  one-cycle pulse, fetch complete
i_rdata  out  DATA_W  fetched instruction, valid with i_ack
d_req  in  1  data request, held until d_ack
d_we  in  1  1=store, 0=load
d_be  in  4  byte enables for stores
d_addr  in  ADDR_W  data address
d_wdata  in  DATA_W  store data
d_ack  out  1  one-cycle pulse, data access complete
d_rdata  out  DATA_W  load data, valid with d_ack
mem_req  out  1  memory request, held until mem_ready
mem_we  out  1  write enable
mem_be  out  4  byte enables (4'hF for reads)
mem_addr  out  ADDR_W  memory address
mem_wdata  out  DATA_W  memory write data
mem_ready  in  1  memory accepts request this cycle
mem_rvalid  in  1  read data valid this cycle
mem_rdata  in  DATA_W  read data
err  out  1  sticky timeout flag (ARB_TIMEOUT_EN only; otherwise tied 0)

Behaviour:
- Clock and reset: single clock clk; reset is synchronous and active-high.
- Reset: state IDLE; i_ack, d_ack, mem_req, mem_we, err = 0; mem_be = 0; addr/data outputs, i_rdata, d_rdata = 0; streak counter = 0.
- FSM states: IDLE, REQ, WAIT, ACK. All outputs are registered.
- IDLE: if d_req and (!i_req or streak < MAX_D_STREAK), grant data. Else if i_req, grant fetch. On grant: latch owner, address, we, be, and wdata into mem_* outputs; set mem_req=1; go to REQ.
- Streak: increments on a data grant while i_req=1, saturating at MAX_D_STREAK. It clears on any fetch grant.
- REQ: hold mem_* stable until mem_ready=1 in a cycle. On that cycle mem_req drops. For a write, go to ACK. For a read, go to WAIT.
- WAIT: on mem_rvalid=1, capture mem_rdata into the owner's rdata register and go to ACK.
- ACK: pulse the owner's ack for exactly one cycle, then return to IDLE. A new grant is possible in the cycle after ACK, never in the ACK cycle itself.
- Latency: with request in cycle 0 and mem_ready=1 in cycle 1, a store acks in cycle 2. For a load with mem_rvalid in cycle 2, the ack is in cycle 3 with rdata.
- i_rdata and d_rdata hold their last value between acks. The non-owner's ack stays 0.
- Requester drops req before ack (protocol violation): the transaction still completes and the ack still pulses.
- mem_rvalid in IDLE, REQ, or ACK is ignored. This includes a late response after reset.
- Simultaneous i_req and d_req: data wins unless the streak limit is reached.
- Reset mid-transaction: the transaction is abandoned immediately and no ack is issued.

Optional Feature:
ARB_TIMEOUT_EN: when defined, a cycle counter runs in WAIT. If it reaches TIMEOUT without mem_rvalid, the FSM goes to ACK, owner rdata = 32'hDEADBEEF, and err is set sticky until reset. When undefined, WAIT waits forever, the counter is absent, and err is constant 0.

Decomposition:
- Shared package/header arb_defs: FSM state encodings, OWNER_I/OWNER_D constants, BAD_DATA = 32'hDEADBEEF.
- One sub-module, arb_timeout_cnt: a loadable counter with terminal-count flag, instantiated only under ARB_TIMEOUT_EN.

Test Plan:
- Fetch only: i_req, i_addr=0x100; mem_ready=1 in cycle 1, mem_rvalid with 0x00500093 in cycle 2 -> i_ack in cycle 3, i_rdata=0x00500093, mem_addr=0x100, mem_be=4'hF.
- Store: d_req, d_we=1, d_be=4'b0011, d_addr=0x2004, d_wdata=0xCAFE1234; mem_ready delayed 3 cycles -> mem_* held stable, d_ack 1 cycle after the mem_ready cycle, no WAIT state.
- Contention: i_req and d_req held constantly, all zero-wait -> grant order D,D,D,D,I,D,D,D,D,I.
- Reset during WAIT, then mem_rvalid one cycle after reset -> no acks, FSM stays IDLE, d_rdata stays 0.
- ARB_TIMEOUT_EN, TIMEOUT=8: load with no mem_rvalid -> d_ack after 8 WAIT cycles, d_rdata=0xDEADBEEF, err=1 and held until reset.
